tcdm_apb_bridge: RTL and testbench

downstream stage for one contiguous-crossbar slave port. Converts a TCDM slave port with a 1-cycle-latency contract into an APB master. Grant is held off until the APB transfer finishes.

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32: width of paddr_o, taken from tcdm_add_i[APB_ADDR_WIDTH-1:0].
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-003 Parameter ERROR_RESPONSE, default 32'hBADACCE5: read data returned on timeout.
REQ-004 clk_i  in  1  clock; one clock domain.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 tcdm_req_i  in  1  request; held stable by the master until grant.
REQ-007 tcdm_add_i  in  32  byte address.
REQ-008 tcdm_wen_i  in  1  1 = read, 0 = write.
REQ-009 tcdm_wdata_i  in  32  write data.
REQ-010 tcdm_be_i  in  4  byte enables.
REQ-011 tcdm_gnt_o  out  1  grant.
REQ-012 tcdm_r_valid_o  out  1  response valid.
REQ-013 tcdm_r_rdata_o  out  32  response data.
REQ-014 tcdm_r_opc_o  out  1  error flag.
REQ-015 paddr_o  out  APB_ADDR_WIDTH; pwdata_o  out  32; pwrite_o  out  1; pstrb_o  out  4; psel_o  out  1; penable_o  out  1.
REQ-016 prdata_i  in  32; pready_i  in  1; pslverr_i  in  1.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETUP, ACCESS.
REQ-018 IDLE with tcdm_req_i=1: latch add, wen, wdata and be into holding registers, then go to SETUP.
REQ-019 SETUP: psel_o=1, penable_o=0; unconditionally go to ACCESS next cycle.
REQ-020 ACCESS: psel_o=1, penable_o=1; the APB outputs SHALL be driven only from the holding registers and stay stable.
REQ-021 Outputs paddr_o, pwrite_o (= ~wen), pstrb_o (= be on writes, 4'b0 on reads) and pwdata_o (= wdata on writes, 0 on reads) SHALL also come from the holding registers.
REQ-022 ACCESS with pready_i=1: tcdm_gnt_o=1 combinationally in that same cycle, then go to IDLE.
REQ-023 At the completing cycle, register r_rdata = prdata_i for reads or 32'h0 for writes, and r_opc = pslverr_i.
REQ-024 tcdm_r_valid_o SHALL be 1 for exactly one cycle, the cycle after tcdm_gnt_o=1. The response registers SHALL hold their value until the next response.
REQ-025 tcdm_gnt_o SHALL be 0 in IDLE and SETUP. Minimum latency: request to grant = 2 cycles (SETUP, ACCESS), grant to r_valid = 1 cycle.
REQ-026 Back-to-back: a request present in the cycle r_valid=1 (IDLE) SHALL be accepted into SETUP without a bubble.
REQ-027 Timeout: an ACCESS-cycle counter of width $clog2(TIMEOUT_CYCLES+1) SHALL be cleared on entry to ACCESS.
REQ-028 When TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 with pready_i=0: assert tcdm_gnt_o, register r_opc=1 and r_rdata=ERROR_RESPONSE (reads and writes alike), and go to IDLE.
REQ-029 pready_i=1 on the timeout cycle SHALL take priority: normal completion, no error.
REQ-030 With TIMEOUT_CYCLES=0 the counter SHALL never abort.
REQ-031 tcdm_req_i dropping after acceptance (contract violation) SHALL NOT abort the transfer: APB completes and gnt/r_valid are still issued.
REQ-032 prdata_i and pslverr_i SHALL be sampled only in the ACCESS cycle with pready_i=1.

Reset
REQ-033 rst_ni=0 SHALL asynchronously force state IDLE and clear the counter, holding registers and response registers.
REQ-034 During reset: psel_o=0, penable_o=0, tcdm_gnt_o=0, tcdm_r_valid_o=0, tcdm_r_opc_o=0, tcdm_r_rdata_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0, pwrite_o=0.
REQ-035 Reset asserted mid-transfer SHALL drop psel_o immediately. No response SHALL be issued for the aborted transfer after release.

Verification
REQ-036 Read, add=32'h1A10_2004, pready_i=1 at first ACCESS, prdata_i=32'hCAFE_F00D -> psel at cycle 1, penable at cycle 2, gnt at cycle 2, r_valid at cycle 3, r_rdata=32'hCAFEF00D, r_opc=0.
REQ-037 Write, wdata=32'h0000_00A5, be=4'b0001, pready_i held 0 for 3 ACCESS cycles -> pwrite=1, pstrb=4'b0001, pwdata stable through ACCESS, gnt in the 4th ACCESS cycle, r_valid next cycle, r_rdata=0.
REQ-038 Read with pslverr_i

---
 rtl/tcdm_apb_bridge.sv | 111 +++++++++++
 tb/tb_tcdm_apb_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_apb_bridge.sv
// TCDM slave port to APB master bridge: one transfer in flight, grant withheld
// until the APB access completes or times out, response returned one cycle later.
module tcdm_apb_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_RESPONSE = 32'hBADACCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tcdm_req_i,
  input  logic [31:0]               tcdm_add_i,
  input  logic                      tcdm_wen_i,
  input  logic [31:0]               tcdm_wdata_i,
  input  logic [3:0]                tcdm_be_i,
  output logic                      tcdm_gnt_o,
  output logic                      tcdm_r_valid_o,
  output logic [31:0]               tcdm_r_rdata_o,
  output logic                      tcdm_r_opc_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  // A one-bit counter is kept even when the timeout is disabled so the width stays legal.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [APB_ADDR_WIDTH-1:0] hold_add;
  logic                      hold_write;
  logic [31:0]               hold_wdata;
  logic [3:0]                hold_be;
  logic                      r_valid;
  logic [31:0]               r_rdata;
  logic                      r_opc;
  logic                      timeout;
  logic                      done;

  assign timeout = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST) && !pready_i;
  assign done    = (state == ACCESS) && (pready_i || timeout);

  assign tcdm_gnt_o     = done;
  assign tcdm_r_valid_o = r_valid;
  assign tcdm_r_rdata_o = r_rdata;
  assign tcdm_r_opc_o   = r_opc;

  // Write direction is held as ~wen so that a cleared register means "no write".
  assign psel_o    = (state != IDLE);
  assign penable_o = (state == ACCESS);
  assign paddr_o   = hold_add;
  assign pwrite_o  = hold_write;
  assign pstrb_o   = hold_write ? hold_be : 4'b0000;
  assign pwdata_o  = hold_write ? hold_wdata : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_add   <= '0;
      hold_write <= 1'b0;
      hold_wdata <= 32'h0;
      hold_be    <= 4'b0000;
      r_valid    <= 1'b0;
      r_rdata    <= 32'h0;
      r_opc      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tcdm_req_i) begin
            hold_add   <= tcdm_add_i[APB_ADDR_WIDTH-1:0];
            hold_write <= ~tcdm_wen_i;
            hold_wdata <= tcdm_wdata_i;
            hold_be    <= tcdm_be_i;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          // A ready slave wins over the timeout in the same cycle.
          if (pready_i) begin
            r_valid <= 1'b1;
            r_rdata <= hold_write ? 32'h0 : prdata_i;
            r_opc   <= pslverr_i;
            state   <= IDLE;
          end else if (timeout) begin
            r_valid <= 1'b1;
            r_rdata <= ERROR_RESPONSE;
            r_opc   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_apb_bridge.sv
// Directed bench for tcdm_apb_bridge with a 4-cycle timeout: read, stalled write,
// slave error, timeout, back-to-back reads and reset during ACCESS.
module tb_tcdm_apb_bridge;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int nvec = 0;
  int nerr = 0;

  tcdm_apb_bridge #(
    .APB_ADDR_WIDTH (32),
    .TIMEOUT_CYCLES (4),
    .ERROR_RESPONSE (32'hBADACCE5)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tcdm_req_i     (req),
    .tcdm_add_i     (add),
    .tcdm_wen_i     (wen),
    .tcdm_wdata_i   (wdata),
    .tcdm_be_i      (be),
    .tcdm_gnt_o     (gnt),
    .tcdm_r_valid_o (r_valid),
    .tcdm_r_rdata_o (r_rdata),
    .tcdm_r_opc_o   (r_opc),
    .paddr_o        (paddr),
    .pwdata_o       (pwdata),
    .pwrite_o       (pwrite),
    .pstrb_o        (pstrb),
    .psel_o         (psel),
    .penable_o      (penable),
    .prdata_i       (prdata),
    .pready_i       (pready),
    .pslverr_i      (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; add = '0; wen = 1'b1; wdata = '0; be = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_opc", 32'(r_opc), 32'd0);
    chk("rst_rdata", r_rdata, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    cyc(); rst_n = 1'b1;

    // Single read, ready at first ACCESS
    cyc(); req = 1'b1; add = 32'h1A10_2004; wen = 1'b1; wdata = 32'h1234_5678; be = 4'hF;
    pready = 1'b1; prdata = 32'hCAFE_F00D; #1;
    chk("rd_c0_psel", 32'(psel), 32'd0);
    chk("rd_c0_gnt", 32'(gnt), 32'd0);
    cyc(); #1;
    chk("rd_c1_psel", 32'(psel), 32'd1);
    chk("rd_c1_penable", 32'(penable), 32'd0);
    chk("rd_c1_gnt", 32'(gnt), 32'd0);
    chk("rd_c1_paddr", paddr, 32'h1A10_2004);
    chk("rd_c1_pwrite", 32'(pwrite), 32'd0);
    chk("rd_c1_pstrb", 32'(pstrb), 32'd0);
    chk("rd_c1_pwdata", pwdata, 32'h0);
    cyc(); #1;
    chk("rd_c2_penable", 32'(penable), 32'd1);
    chk("rd_c2_gnt", 32'(gnt), 32'd1);
    cyc(); req = 1'b0; #1;
    chk("rd_c3_rvalid", 32'(r_valid), 32'd1);
    chk("rd_c3_rdata", r_rdata, 32'hCAFE_F00D);
    chk("rd_c3_opc", 32'(r_opc), 32'd0);
    chk("rd_c3_psel", 32'(psel), 32'd0);
    cyc(); #1;
    chk("rd_c4_rvalid", 32'(r_valid), 32'd0);
    chk("rd_c4_rdata_hold", r_rdata, 32'hCAFE_F00D);

    // Write stalled 3 ACCESS cycles; ready arrives on the last timeout cycle
    cyc(); req = 1'b1; add = 32'h0000_0040; wen = 1'b0; wdata = 32'h0000_00A5; be = 4'b0001;
    pready = 1'b0; prdata = 32'hDEAD_BEEF; #1;
    cyc(); wdata = 32'hFFFF_FFFF; be = 4'hF; #1;
    chk("wr_setup_pwrite", 32'(pwrite), 32'd1);
    chk("wr_setup_pstrb", 32'(pstrb), 32'b0001);
    chk("wr_setup_pwdata", pwdata, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("wr_wait_penable", 32'(penable), 32'd1);
      chk("wr_wait_gnt", 32'(gnt), 32'd0);
      chk("wr_wait_pwdata", pwdata, 32'h0000_00A5);
      chk("wr_wait_pstrb", 32'(pstrb), 32'b0001);
    end
    cyc(); pready = 1'b1; #1;
    chk("wr_done_gnt", 32'(gnt), 32'd1);
    cyc(); req = 1'b0; pready = 1'b0; #1;
    chk("wr_rvalid", 32'(r_valid), 32'd1);
    chk("wr_rdata", r_rdata, 32'h0);
    chk("wr_opc", 32'(r_opc), 32'd0);

    // Read completing with slave error
    cyc(); req = 1'b1; add = 32'h0000_0008; wen = 1'b1; pslverr = 1'b1; prdata = 32'h0; #1;
    cyc(); #1;
    cyc(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h55AA_1234; #1;
    chk("err_gnt", 32'(gnt), 32'd1);
    cyc(); req = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; #1;
    chk("err_rvalid", 32'(r_valid), 32'd1);
    chk("err_opc", 32'(r_opc), 32'd1);
    chk("err_rdata", r_rdata, 32'h55AA_1234);

    // Timeout: ready never asserted
    cyc(); req = 1'b1; add = 32'h0000_000C; wen = 1'b1; prdata = 32'h7777_7777; #1;
    cyc(); #1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("to_wait_gnt", 32'(gnt), 32'd0);
    end
    cyc(); #1;
    chk("to_gnt", 32'(gnt), 32'd1);
    cyc(); req = 1'b0; #1;
    chk("to_psel", 32'(psel), 32'd0);
    chk("to_rvalid", 32'(r_valid), 32'd1);
    chk("to_opc", 32'(r_opc), 32'd1);
    chk("to_rdata", r_rdata, 32'hBADACCE5);

    // Back-to-back reads; second request dropped after acceptance
    cyc(); req = 1'b1; add = 32'h0000_0100; wen = 1'b1; pready = 1'b1; prdata = 32'h1111_1111; #1;
    cyc(); #1;
    cyc(); #1;
    chk("b2b_gnt1", 32'(gnt), 32'd1);
    cyc(); add = 32'h0000_0104; prdata = 32'h2222_2222; #1;
    chk("b2b_rvalid1", 32'(r_valid), 32'd1);
    chk("b2b_rdata1", r_rdata, 32'h1111_1111);
    cyc(); req = 1'b0; #1;
    chk("b2b_setup2_psel", 32'(psel), 32'd1);
    chk("b2b_setup2_penable", 32'(penable), 32'd0);
    chk("b2b_setup2_paddr", paddr, 32'h0000_0104);
    chk("b2b_gap_rvalid", 32'(r_valid), 32'd0);
    cyc(); #1;
    chk("b2b_gnt2", 32'(gnt), 32'd1);
    chk("b2b_gap2_rvalid", 32'(r_valid), 32'd0);
    cyc(); pready = 1'b0; #1;
    chk("b2b_rvalid2", 32'(r_valid), 32'd1);
    chk("b2b_rdata2", r_rdata, 32'h2222_2222);

    // Reset asserted during ACCESS
    cyc(); req = 1'b1; add = 32'h0000_0200; wen = 1'b1; pready = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("rma_penable", 32'(penable), 32'd1);
    rst_n = 1'b0; #1;
    chk("rma_psel", 32'(psel), 32'd0);
    chk("rma_penable_drop", 32'(penable), 32'd0);
    chk("rma_gnt", 32'(gnt), 32'd0);
    cyc(); cyc(); rst_n = 1'b1; req = 1'b0; pready = 1'b1; prdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rma_post_rvalid", 32'(r_valid), 32'd0);
      chk("rma_post_psel", 32'(psel), 32'd0);
    end
    cyc(); req = 1'b1; add = 32'h0000_0300; wen = 1'b1; prdata = 32'h3333_3333; #1;
    cyc(); #1;
    cyc(); #1;
    chk("rma_next_gnt", 32'(gnt), 32'd1);
    cyc(); req = 1'b0; pready = 1'b0; #1;
    chk("rma_next_rvalid", 32'(r_valid), 32'd1);
    chk("rma_next_rdata", r_rdata, 32'h3333_3333);
    chk("rma_next_opc", 32'(r_opc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
